// File: rtl/spi_controller.sv
`timescale 1ns/1ps
// SPI mode-0 host controller for 16-bit register frames
// {rw, addr[6:0], data[7:0]}, MSB first, one frame in flight.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI,
  input  logic       CIPO
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP
  } state_t;

  localparam logic [7:0] LP_DIV_LAST = 8'(CLK_DIV - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_div;
  logic [3:0]  r_bit;
  logic [15:0] r_shift;
  logic [7:0]  r_rx;
  logic        r_wr;
  logic        r_cipo_s1;
  logic        r_cipo_s2;
  logic        w_last;
  logic        w_accept;
  logic        w_sclk;
  logic        w_ncs;
  logic        w_ready;
  logic        w_done;

  assign w_last   = (r_div == LP_DIV_LAST);
  assign w_accept = req_valid && req_ready;
  assign COPI     = r_shift[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SETUP;
      S_SETUP: if (w_last)   w_next = S_HIGH;
      S_HIGH:  if (w_last)   w_next = S_LOW;
      S_LOW:   if (w_last)
                 w_next = (r_bit == 4'd15) ? S_GAP : S_HIGH;
      S_GAP:   if (w_last)   w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state, then registered
  always_comb begin
    w_sclk  = (w_next == S_HIGH);
    w_ncs   = !(w_next == S_SETUP ||
                w_next == S_HIGH  ||
                w_next == S_LOW);
    w_ready = (w_next == S_IDLE);
    w_done  = (r_state == S_LOW) && (w_next == S_GAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SCLK      <= 1'b0;
      nCS       <= 1'b1;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      SCLK      <= w_sclk;
      nCS       <= w_ncs;
      req_ready <= w_ready;
      busy      <= !w_ready;
      rsp_valid <= w_done;
      if (w_done) rsp_rdata <= r_wr ? 8'h00 : r_rx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cipo_s1 <= 1'b0;
      r_cipo_s2 <= 1'b0;
    end else begin
      r_cipo_s1 <= CIPO;
      r_cipo_s2 <= r_cipo_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_div <= 8'h00;
    else if (r_state == S_IDLE || w_next != r_state)
      r_div <= 8'h00;
    else
      r_div <= r_div + 8'h01;
  end

  // Zeros enter the shifter so COPI is 0 once the frame ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= 16'h0000;
      r_rx    <= 8'h00;
      r_bit   <= 4'd0;
      r_wr    <= 1'b0;
    end else if (w_accept) begin
      r_shift <= {req_rw, req_addr,
                  req_rw ? req_wdata : 8'h00};
      r_wr    <= req_rw;
      r_bit   <= 4'd0;
    end else if (r_state == S_HIGH && w_last) begin
      r_shift <= {r_shift[14:0], 1'b0};
      r_rx    <= {r_rx[6:0], r_cipo_s2};
    end else if (r_state == S_LOW && w_last &&
                 r_bit != 4'd15) begin
      r_bit   <= r_bit + 4'd1;
    end
  end

endmodule
